// File: rtl/sc_fir_pkg.sv
// Shared constants and types for the SC FIR datapath.
// Used by the stream encoder and its de Bruijn LFSR.
package sc_fir_pkg;

  localparam int N      = 12;
  localparam int LENGTH = 19;
  localparam int POW2N  = 1 << N;

  typedef logic [N:0] tap_t;
  typedef tap_t [LENGTH-1:0] taps_t;

  localparam logic [N-1:0] LFSR_POLY    = 12'hE08;
  localparam logic [N-1:0] SEED_DEFAULT = 12'hACE;
  localparam tap_t         TAP_MAX      = tap_t'(POW2N);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } enc_state_t;

  function automatic tap_t tap_sat(input tap_t v);
    return (v > TAP_MAX) ? TAP_MAX : v;
  endfunction

endpackage

// File: rtl/sc_lfsr_db.sv
// 12-bit Fibonacci de Bruijn LFSR, full 2^N period.
// Includes the all-zero state via the NOR-of-low-bits term.
module sc_lfsr_db
  import sc_fir_pkg::*;
#(
  parameter logic [N-1:0] SEED = SEED_DEFAULT
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic         enable,
  output logic [N-1:0] value
);

  logic fb;

  assign fb = (^(value & LFSR_POLY)) ^ (value[N-2:0] == '0);

  // state register: restart on load, step on enable
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      value <= SEED;
    end else if (load) begin
      value <= SEED;
    end else if (enable) begin
      value <= {value[N-2:0], fb};
    end
  end

endmodule

// File: rtl/sc_stream_encoder.sv
// Binary-to-stochastic encoder: tap delay line, frame
// sequencer and comparator bank feeding the weighted adder.
module sc_stream_encoder
  import sc_fir_pkg::*;
#(
  parameter logic [N-1:0] SEED = SEED_DEFAULT
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [N:0]              sample_in,
  input  logic                    sample_valid,
  output logic                    sample_ready,
  output logic [LENGTH-1:0][N:0]  taps,
  output logic [N-1:0]            r_y,
  output logic [N-1:0]            sel_bits,
  output logic [LENGTH-1:0]       sn_bits,
  output logic                    start,
  output logic                    frame_done
);

  enc_state_t   state;
  enc_state_t   state_nxt;
  logic         accept;
  logic         step;
  logic         ry_live;
  logic [N-1:0] lfsr_q;

  // handshake, frame markers and next state
  always_comb begin
    start        = 1'b0;
    frame_done   = 1'b0;
    sample_ready = 1'b0;
    state_nxt    = state;
    unique case (state)
      IDLE: begin
        sample_ready = 1'b1;
      end
      RUN: begin
        start        = (sel_bits == '0);
        frame_done   = (sel_bits == '1);
        sample_ready = frame_done;
      end
      default: ;
    endcase
    accept = sample_valid & sample_ready;
    if (accept) begin
      state_nxt = RUN;
    end else if (frame_done) begin
      state_nxt = IDLE;
    end
  end

  assign step = (state == RUN) & ~frame_done;

  // FSM state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // delay line and frame cycle counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      taps     <= '0;
      sel_bits <= '1;
      ry_live  <= 1'b0;
    end else if (accept) begin
      taps     <= {taps[LENGTH-2:0], tap_sat(sample_in)};
      sel_bits <= '0;
      ry_live  <= 1'b1;
    end else if (step) begin
      sel_bits <= sel_bits + 1'b1;
    end
  end

  sc_lfsr_db #(
    .SEED (SEED)
  ) u_lfsr (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (accept),
    .enable  (step),
    .value   (lfsr_q)
  );

  // r_y reads zero until the first frame has loaded the LFSR
  assign r_y = ry_live ? lfsr_q : '0;

  // per-tap comparators, unsigned against zero-extended r_y
  always_comb begin
    sn_bits = '0;
    for (int i = 0; i < LENGTH; i++) begin
      sn_bits[i] = (taps[i] > {1'b0, r_y});
    end
  end

endmodule

// File: tb/tb_sc_stream_encoder.sv
// Bench for sc_stream_encoder: directed frames plus random
// samples against a delay-line / popcount reference model.
module tb_sc_stream_encoder;

  localparam int          NB   = 12;
  localparam int          LEN  = 19;
  localparam int          P    = 4096;
  localparam logic [11:0] SEED = 12'hACE;

  logic                   clock = 1'b0;
  logic                   reset_n = 1'b1;
  logic [NB:0]            sample_in = '0;
  logic                   sample_valid = 1'b0;
  logic                   sample_ready;
  logic [LEN-1:0][NB:0]   taps;
  logic [NB-1:0]          r_y;
  logic [NB-1:0]          sel_bits;
  logic [LEN-1:0]         sn_bits;
  logic                   start;
  logic                   frame_done;

  sc_stream_encoder dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .taps         (taps),
    .r_y          (r_y),
    .sel_bits     (sel_bits),
    .sn_bits      (sn_bits),
    .start        (start),
    .frame_done   (frame_done)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int pc [LEN];
  bit seen [P];
  int ry_seq [P];
  int ref_seq [P];
  int done_cnt, done_pos, start_cnt, distinct;
  int model [$];

  task automatic check(input string tag, input longint obs,
                       input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > P) ? P : v;
  endfunction

  task automatic model_clear();
    model.delete();
    for (int i = 0; i < LEN; i++) model.push_back(0);
  endtask

  task automatic model_push(input int v);
    model.push_front(sat(v));
    void'(model.pop_back());
  endtask

  task automatic tap_check(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < LEN; i++)
      if (int'(taps[i]) != model[i]) bad++;
    check(tag, bad, 0);
  endtask

  // drive one sample from an idle negedge; end in frame cycle 0
  task automatic send(input int v, input string tag);
    sample_in = (NB+1)'(v);
    sample_valid = 1'b1;
    check({tag, "_ready"}, sample_ready, 1);
    @(negedge clock);
    sample_valid = 1'b0;
    model_push(v);
    check({tag, "_start"}, start, 1);
    check({tag, "_sel0"}, sel_bits, 0);
  endtask

  // observe a whole frame; ends at the negedge of its last cycle
  task automatic collect();
    done_cnt = 0;
    done_pos = -1;
    start_cnt = 0;
    distinct = 0;
    for (int i = 0; i < LEN; i++) pc[i] = 0;
    for (int k = 0; k < P; k++) seen[k] = 1'b0;
    for (int k = 0; k < P; k++) begin
      for (int i = 0; i < LEN; i++) pc[i] += int'(sn_bits[i]);
      ry_seq[k] = int'(r_y);
      seen[r_y] = 1'b1;
      if (frame_done) begin
        done_cnt++;
        done_pos = k;
      end
      if (start) start_cnt++;
      if (k < P-1) @(negedge clock);
    end
    for (int k = 0; k < P; k++) if (seen[k]) distinct++;
  endtask

  task automatic frame_check(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < LEN; i++) if (pc[i] != model[i]) bad++;
    check({tag, "_pc0"}, pc[0], model[0]);
    check({tag, "_pc_all"}, bad, 0);
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_done_pos"}, done_pos, P-1);
    check({tag, "_start_cnt"}, start_cnt, 1);
    check({tag, "_ry_distinct"}, distinct, P);
    tap_check({tag, "_taps"});
  endtask

  task automatic idle_check(input string tag);
    check({tag, "_ready"}, sample_ready, 1);
    check({tag, "_sel"}, sel_bits, P-1);
    check({tag, "_start"}, start, 0);
    check({tag, "_done"}, frame_done, 0);
  endtask

  initial begin
    int vals [5];
    int s1, s2, bad, guard, bad_rdy;
    model_clear();

    // reset held for three cycles
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clock);
    idle_check("rst");
    check("rst_ry", r_y, 0);
    tap_check("rst_taps");
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
    idle_check("post_rst");
    tap_check("post_rst_taps");

    // first frame, also the reference r_y sequence
    send(1000, "f1000");
    check("f1000_ry0", r_y, SEED);
    collect();
    frame_check("f1000");
    for (int k = 0; k < P; k++) ref_seq[k] = ry_seq[k];
    @(negedge clock);
    idle_check("f1000_idle");

    // bounds and random samples
    vals[0] = 0;
    vals[1] = 4096;
    vals[2] = 5000;
    vals[3] = int'($urandom_range(0, 8191));
    vals[4] = int'($urandom_range(0, 4096));
    for (int j = 0; j < 5; j++) begin
      send(vals[j], $sformatf("v%0d", vals[j]));
      check($sformatf("v%0d_tap0", vals[j]), taps[0], sat(vals[j]));
      collect();
      frame_check($sformatf("v%0d", vals[j]));
      @(negedge clock);
    end

    // back-to-back frames with valid held high
    sample_in = 13'd10;
    sample_valid = 1'b1;
    check("b2b_ready", sample_ready, 1);
    @(negedge clock);
    model_push(10);
    check("b2b1_start", start, 1);
    sample_in = 13'd20;
    collect();
    frame_check("b2b1");
    check("b2b1_end_ready", sample_ready, 1);
    @(negedge clock);
    model_push(20);
    check("b2b2_start", start, 1);
    check("b2b2_sel", sel_bits, 0);
    sample_in = 13'd30;
    collect();
    frame_check("b2b2");
    @(negedge clock);
    model_push(30);
    check("b2b3_start", start, 1);
    check("b2b3_sel", sel_bits, 0);
    sample_valid = 1'b0;
    collect();
    frame_check("b2b3");
    check("b2b3_tap0", taps[0], 30);
    check("b2b3_tap1", taps[1], 20);
    check("b2b3_tap2", taps[2], 10);
    check("b2b3_pc1", pc[1], 20);
    check("b2b3_pc2", pc[2], 10);
    @(negedge clock);
    idle_check("b2b_idle");

    // backpressure from mid-frame until the frame_done cycle
    s1 = int'($urandom_range(0, 8191));
    s2 = int'($urandom_range(0, 8191));
    send(s1, "bp1");
    repeat (100) @(negedge clock);
    check("bp_sel100", sel_bits, 100);
    sample_in = (NB+1)'(s2);
    sample_valid = 1'b1;
    check("bp_not_ready", sample_ready, 0);
    bad = 0;
    bad_rdy = 0;
    guard = 0;
    while (!frame_done && guard < P) begin
      if (sample_ready) bad_rdy++;
      for (int i = 0; i < LEN; i++)
        if (int'(taps[i]) != model[i]) bad++;
      @(negedge clock);
      guard++;
    end
    check("bp_reached_done", frame_done, 1);
    check("bp_wait_cycles", guard, P-1-100);
    check("bp_ready_low", bad_rdy, 0);
    check("bp_taps_stable", bad, 0);
    check("bp_done_ready", sample_ready, 1);
    @(negedge clock);
    sample_valid = 1'b0;
    model_push(s2);
    check("bp2_start", start, 1);
    tap_check("bp2_taps");

    // reset in the middle of a frame
    repeat (2000) @(negedge clock);
    check("mr_sel2000", sel_bits, 2000);
    reset_n = 1'b0;
    #1;
    model_clear();
    tap_check("mr_taps");
    idle_check("mr");
    check("mr_ry", r_y, 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    idle_check("mr_rel");
    send(777, "mr777");
    collect();
    frame_check("mr777");
    bad = 0;
    for (int k = 0; k < P; k++) if (ry_seq[k] != ref_seq[k]) bad++;
    check("mr_ry_replay", bad, 0);
    @(negedge clock);
    idle_check("end_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sc_stream_encoder.md
Name: sc_stream_encoder

Overview:
Binary-to-stochastic front end for the SC FIR datapath, the encoding end of the stream that the hardware-weighted adder decodes back to binary.
- Accepts one binary sample per frame over a valid/ready handshake and shifts it into a LENGTH-tap delay line.
- Runs one 2^N-cycle frame per sample, driving taps, the comparator random number r_y, sel_bits and start to the weighted adder.
- Emits the per-tap stochastic bits for other SC consumers.

Parameters:
N, 12, binary sample width is N+1; frame length 2^N cycles
LENGTH, 19, number of filter taps (ORDER+1)
SEED, 12'hACE, LFSR restart value each frame; must be nonzero

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
sample_in  in  N+1  new binary sample, 0..2^N
sample_valid  in  1  sample_in valid
sample_ready  out  1  encoder can accept a sample this cycle
taps  out  LENGTH x (N+1)  delay line; taps[0] is the newest sample
r_y  out  N  per-cycle random number, registered
sel_bits  out  N  frame cycle index 0..2^N-1, registered
sn_bits  out  LENGTH  combinational: sn_bits[i] = (taps[i] > r_y)
start  out  1  first cycle of a frame
frame_done  out  1  last cycle of a frame (sel_bits == 2^N-1 in RUN)

Behaviour:
- Reset values (async, on reset_n low):
  - taps all 0; state IDLE; sel_bits = 2^N-1 (keeps the downstream accumulator cleared); r_y = 0.
  - lfsr = SEED; start = 0; frame_done = 0.
  - sample_ready = 1 after reset is released.
- FSM has two states, IDLE and RUN.
- IDLE:
  - sample_ready = 1; sel_bits held at 2^N-1.
  - Accept on sample_valid & sample_ready: taps[0] <= sample_in, taps[i] <= taps[i-1]; lfsr <= SEED; sel_bits <= 0; state <= RUN.
- RUN:
  - start = 1 only when sel_bits == 0.
  - Each cycle, sel_bits increments by 1 and the LFSR advances by one step.
  - r_y = the current LFSR state.
  - sample_ready = 0 except in the frame_done cycle.
- Frame end (sel_bits == 2^N-1): frame_done = 1 and sample_ready = 1.
  - Accept in this cycle: back-to-back frame, next cycle is RUN with sel_bits = 0 and start = 1; no idle gap.
  - No accept: state <= IDLE and sel_bits stays at 2^N-1.
- Latency: accept edge -> next cycle is frame cycle 0 (start high) -> frame_done 2^N-1 cycles later.
- Frame length is exactly 2^N RUN cycles. taps are stable for the whole frame.
- LFSR is a 12-bit Fibonacci de Bruijn sequence (N fixed at 12 for this polynomial):
  - Polynomial x^12+x^11+x^10+x^4+1.
  - Feedback is XORed with (lfsr[N-2:0] == 0), so the all-zero state is included.
  - Period is 2^N, and every value 0..2^N-1 appears exactly once per frame.
- Consequence of the full-period LFSR: popcount of sn_bits[i] over a frame equals min(taps[i], 2^N) exactly.
- sample_valid while not ready: ignored; the producer holds the sample; no state change.
- reset_n low mid-frame: immediate return to reset values; partial frame discarded; taps cleared.
- sample_in > 2^N: saturate to 2^N on capture.
- Arithmetic:
  - sel_bits is an N-bit counter.
  - Comparison is unsigned (N+1)-bit vs zero-extended r_y.
  - No other arithmetic.

Decomposition:
- Shared package sc_fir_pkg holds:
  - N, LENGTH and POW2N constants.
  - The tap_t typedef (logic [N:0]) and the taps array typedef.
  - LFSR polynomial tap mask and default SEED.
  - The enum for IDLE/RUN.
- One sub-module, sc_lfsr_db: de Bruijn LFSR with load (SEED) and enable, async active-low reset.
  - It is also reusable as the random-number source elsewhere in the SC datapath.

Test Plan:
- Reset: hold reset_n low for 3 cycles -> sample_ready=1, sel_bits=4095, start=0, frame_done=0, all taps=0; release -> unchanged until sample_valid.
- Single frame, sample_in=1000:
  - start is high exactly 1 cycle after accept.
  - frame_done is high 4095 cycles later.
  - popcount(sn_bits[0]) over the frame = 1000.
  - Bench collects r_y: 4096 distinct values covering 0..4095.
- Bounds: sample_in=0 -> 0 ones on sn_bits[0]; sample_in=4096 -> 4096 ones; sample_in=5000 -> captured as 4096.
- Delay line and back-to-back: feed samples 10, 20, 30 with sample_valid held high.
  - Frames are contiguous: sel_bits goes 4095 -> 0 with start high, no gap.
  - In frame 3: taps[0]=30, taps[1]=20, taps[2]=10, and popcounts on sn_bits[0..2] = 30, 20, 10.
- Backpressure: assert sample_valid at sel_bits=100 of a running frame -> sample_ready=0 and no tap shift until the frame_done cycle, where the sample is accepted.
- Reset mid-frame: drop reset_n at sel_bits=2000 -> same cycle taps=0, sel_bits=4095, state IDLE; the next accept starts a clean frame with r_y sequence identical to the first frame.
